mem_request_unit: RTL and testbench
===================================

MEM_REQUEST_UNIT -- requirements
Module: mem_request_unit

Interface
REQ-001 Parameter TIMEOUT, default 16, SHALL set the number of consecutive REQ cycles without busAck before a timeout error.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 nRst  input  1  SHALL be the reset, synchronous and active-low.
REQ-004 start  input  1  SHALL be the control unit's qualification that cuOP/addr/storeData are valid this cycle.
REQ-005 cuOP  input  6  SHALL be the decoded op; LB=10, LH=11, LW=12, LBU=13, LHU=14, SB=15, SH=16, SW=17; all other values are non-memory ops.
REQ-006 addr  input  32  SHALL be the effective byte address (ALU output).
REQ-007 storeData  input  32  SHALL be the rs2 value for stores.
REQ-008 busAck  input  1  SHALL be the memory's completion strobe.
REQ-009 busRdata  input  32  SHALL be the memory read word, valid with busAck.
REQ-010 busReq  output  1  SHALL request a bus transfer.
REQ-011 busWen  output  1  SHALL be 1 for a store, 0 for a load.
REQ-012 busAddr  output  32  SHALL be {addr[31:2], 2'b00} of the latched address.
REQ-013 busBen  output  4  SHALL be the byte enables.
REQ-014 busWdata  output  32  SHALL be the lane-replicated store data.
REQ-015 memload  output  32  SHALL be the loaded data right-aligned to bit 0; sign/zero extension is done downstream.
REQ-016 stall  output  1  SHALL hold the pipeline while a transfer is pending.
REQ-017 done  output  1  SHALL pulse for one cycle when a transfer completes.
REQ-018 misalign  output  1  SHALL pulse for one cycle on a misaligned request.
REQ-019 timeoutErr  output  1  SHALL pulse for one cycle on a bus timeout.

Function
REQ-020 FSM states SHALL be IDLE, REQ, DONE, ERR.
REQ-021 IDLE: start with a memory op SHALL latch cuOP, addr and storeData; start with a non-memory op SHALL be ignored.
REQ-022 Misalignment (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0) SHALL go IDLE->ERR with misalign=1 and no bus request; an aligned op SHALL go IDLE->REQ.
REQ-023 REQ: busReq=1; busWen/busAddr/busBen/busWdata SHALL be registered and stable until busAck.
REQ-024 busBen SHALL be 4'b0001<<addr[1:0] for SB, 4'b0011<<addr[1:0] for SH, and 4'b1111 for SW and all loads.
REQ-025 busWdata SHALL be {4{storeData[7:0]}} for SB, {2{storeData[15:0]}} for SH, storeData for SW, and 0 for loads.
REQ-026 busAck in REQ SHALL go REQ->DONE; on a load, memload SHALL capture busRdata >> (8*addr[1:0]) at the same edge.
REQ-027 memload SHALL hold its value until the next load completes; stores SHALL NOT modify it.
REQ-028 A cycle counter SHALL clear on entry to REQ; after TIMEOUT consecutive REQ cycles without busAck the FSM SHALL go REQ->ERR with timeoutErr=1.
REQ-029 busAck arriving in the final timeout cycle SHALL win: go DONE, no error.
REQ-030 DONE SHALL assert done=1 for one cycle and go to IDLE; ERR SHALL assert its error pulse for one cycle and go to IDLE.
REQ-031 stall SHALL be (state==REQ) | (state==IDLE & start & memory op), and SHALL be 0 in DONE and ERR.
REQ-032 start outside IDLE SHALL be ignored; busAck outside REQ SHALL be ignored.
REQ-033 Latency: start at cycle 0 -> busReq at cycle 1; busAck at cycle k -> done at cycle k+1; the minimum is done at cycle 2.

Reset
REQ-034 nRst=0 at a clock edge SHALL force IDLE, clear the counter, and set every output to 0 (including memload), including mid-transfer; busReq SHALL drop at that edge.

Verification
REQ-035 SB, addr=0x1002, storeData=0x000000AB, ack on the 1st REQ cycle -> busAddr=0x1000, busBen=0100, busWdata=0xABABABAB, busWen=1; done at cycle 2.
REQ-036 LHU, addr=0x2002, busRdata=0xBEEF1234 -> memload=0x0000BEEF, busBen=1111, busWen=0.
REQ-037 LW, addr=0x3001 -> misalign pulses one cycle; busReq stays 0; stall=1 only in the start cycle.
REQ-038 LW aligned, no busAck, TIMEOUT=16 -> busReq high 16 cycles; timeoutErr pulses; then IDLE; memload unchanged.
REQ-039 SW in REQ, nRst=0 for one cycle mid-wait -> busReq=0 after that edge; a later busAck produces no done.
REQ-040 start with cuOP=ADD (non-memory) -> no state change, stall=0, busReq=0.

Source files
------------

// File: rtl/mem_request_unit.sv
// mem_request_unit: turns a decoded load/store from the control unit into a
// single bus transfer. It latches the request, drives registered bus fields
// until the memory acknowledges, aligns returned load data to bit 0, and
// reports misaligned accesses and bus timeouts as one-cycle pulses.
module mem_request_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        nRst,
  input  logic        start,
  input  logic [5:0]  cuOP,
  input  logic [31:0] addr,
  input  logic [31:0] storeData,
  input  logic        busAck,
  input  logic [31:0] busRdata,
  output logic        busReq,
  output logic        busWen,
  output logic [31:0] busAddr,
  output logic [3:0]  busBen,
  output logic [31:0] busWdata,
  output logic [31:0] memload,
  output logic        stall,
  output logic        done,
  output logic        misalign,
  output logic        timeoutErr
);

  localparam logic [5:0] OP_LB  = 6'd10;
  localparam logic [5:0] OP_LH  = 6'd11;
  localparam logic [5:0] OP_LW  = 6'd12;
  localparam logic [5:0] OP_LBU = 6'd13;
  localparam logic [5:0] OP_LHU = 6'd14;
  localparam logic [5:0] OP_SB  = 6'd15;
  localparam logic [5:0] OP_SH  = 6'd16;
  localparam logic [5:0] OP_SW  = 6'd17;

  // The counter must be able to represent TIMEOUT-1, the last REQ cycle.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [5:0]        op_q;
  logic [1:0]        offset_q;
  logic [CNT_W-1:0]  cycle_cnt;
  logic              err_is_timeout;

  logic              in_is_mem;
  logic              in_is_store;
  logic              in_misaligned;
  logic [3:0]        in_ben;
  logic [31:0]       in_wdata;
  logic              accept;
  logic              timeout_hit;
  logic              latched_is_load;

  // Decode the incoming op: class, alignment and the bus lane pattern it needs.
  always_comb begin
    in_is_mem     = 1'b0;
    in_is_store   = 1'b0;
    in_misaligned = 1'b0;
    in_ben        = 4'b1111;
    in_wdata      = 32'd0;
    case (cuOP)
      OP_LB, OP_LBU: begin
        in_is_mem = 1'b1;
      end
      OP_LH, OP_LHU: begin
        in_is_mem     = 1'b1;
        in_misaligned = addr[0];
      end
      OP_LW: begin
        in_is_mem     = 1'b1;
        in_misaligned = (addr[1:0] != 2'b00);
      end
      OP_SB: begin
        in_is_mem   = 1'b1;
        in_is_store = 1'b1;
        in_ben      = 4'b0001 << addr[1:0];
        in_wdata    = {4{storeData[7:0]}};
      end
      OP_SH: begin
        in_is_mem     = 1'b1;
        in_is_store   = 1'b1;
        in_misaligned = addr[0];
        in_ben        = 4'b0011 << addr[1:0];
        in_wdata      = {2{storeData[15:0]}};
      end
      OP_SW: begin
        in_is_mem     = 1'b1;
        in_is_store   = 1'b1;
        in_misaligned = (addr[1:0] != 2'b00);
        in_wdata      = storeData;
      end
      default: begin
        in_is_mem = 1'b0;
      end
    endcase
  end

  // A new transfer is only accepted while idle; starts elsewhere are ignored.
  always_comb begin
    accept          = (state == IDLE) && start && in_is_mem;
    timeout_hit     = (state == REQ) && !busAck && (cycle_cnt == CNT_LAST);
    latched_is_load = (op_q >= OP_LB) && (op_q <= OP_LHU);
  end

  // Next-state logic; an acknowledge in the last allowed cycle beats the timeout.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = in_misaligned ? ERR : REQ;
        end
      end
      REQ: begin
        if (busAck) begin
          state_next = DONE;
        end else if (timeout_hit) begin
          state_next = ERR;
        end
      end
      DONE:    state_next = IDLE;
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!nRst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Counts consecutive REQ cycles; restarts at zero each time REQ is entered.
  always_ff @(posedge clk) begin
    if (!nRst) begin
      cycle_cnt <= '0;
    end else if (accept) begin
      cycle_cnt <= '0;
    end else if ((state == REQ) && (state_next == REQ)) begin
      cycle_cnt <= cycle_cnt + 1'b1;
    end
  end

  // Latch the request and its bus image so the bus sees stable values until ack.
  always_ff @(posedge clk) begin
    if (!nRst) begin
      op_q     <= 6'd0;
      offset_q <= 2'b00;
      busWen   <= 1'b0;
      busAddr  <= 32'd0;
      busBen   <= 4'd0;
      busWdata <= 32'd0;
    end else if (accept) begin
      op_q     <= cuOP;
      offset_q <= addr[1:0];
      busWen   <= in_is_store;
      busAddr  <= {addr[31:2], 2'b00};
      busBen   <= in_ben;
      busWdata <= in_wdata;
    end
  end

  // Remember which error to report when the FSM passes through ERR.
  always_ff @(posedge clk) begin
    if (!nRst) begin
      err_is_timeout <= 1'b0;
    end else if (accept) begin
      err_is_timeout <= 1'b0;
    end else if (timeout_hit) begin
      err_is_timeout <= 1'b1;
    end
  end

  // Capture load data right-aligned on the acknowledge edge; stores leave it alone.
  always_ff @(posedge clk) begin
    if (!nRst) begin
      memload <= 32'd0;
    end else if ((state == REQ) && busAck && latched_is_load) begin
      memload <= busRdata >> {offset_q, 3'b000};
    end
  end

  // Status outputs decoded from the current state.
  always_comb begin
    busReq     = (state == REQ);
    done       = (state == DONE);
    misalign   = (state == ERR) && !err_is_timeout;
    timeoutErr = (state == ERR) && err_is_timeout;
    stall      = (state == REQ) || accept;
  end

endmodule

// File: tb/tb_mem_request_unit.sv
// tb_mem_request_unit: directed and randomized load/store transfers checked
// against a behavioural model of access size, lane placement and load return.
module tb_mem_request_unit;

  localparam int TIMEOUT = 16;

  logic        clk;
  logic        nRst;
  logic        start;
  logic [5:0]  cuOP;
  logic [31:0] addr;
  logic [31:0] storeData;
  logic        busAck;
  logic [31:0] busRdata;
  logic        busReq;
  logic        busWen;
  logic [31:0] busAddr;
  logic [3:0]  busBen;
  logic [31:0] busWdata;
  logic [31:0] memload;
  logic        stall;
  logic        done;
  logic        misalign;
  logic        timeoutErr;

  int checks;
  int errors;
  logic [31:0] model_memload;

  mem_request_unit #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .nRst(nRst), .start(start), .cuOP(cuOP), .addr(addr),
    .storeData(storeData), .busAck(busAck), .busRdata(busRdata),
    .busReq(busReq), .busWen(busWen), .busAddr(busAddr), .busBen(busBen),
    .busWdata(busWdata), .memload(memload), .stall(stall), .done(done),
    .misalign(misalign), .timeoutErr(timeoutErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=hang expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Access size in bytes of a memory op.
  function automatic int op_size(input logic [5:0] op);
    if (op == 6'd10 || op == 6'd13 || op == 6'd15) return 1;
    if (op == 6'd11 || op == 6'd14 || op == 6'd16) return 2;
    return 4;
  endfunction

  function automatic bit op_is_store(input logic [5:0] op);
    return (op >= 6'd15) && (op <= 6'd17);
  endfunction

  function automatic bit op_misaligned(input logic [5:0] op, input logic [31:0] a);
    return (a % op_size(op)) != 0;
  endfunction

  function automatic logic [3:0] model_ben(input logic [5:0] op, input logic [31:0] a);
    int sz;
    sz = op_size(op);
    if (!op_is_store(op) || sz == 4) return 4'hF;
    return 4'(((1 << sz) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] model_wdata(input logic [5:0] op, input logic [31:0] d);
    if (!op_is_store(op)) return 32'd0;
    case (op_size(op))
      1:       return (d % 256) * 32'h0101_0101;
      2:       return (d % 65536) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One transfer from IDLE; ack_delay counts REQ cycles before busAck.
  task automatic apply_stimulus(input logic [5:0] op, input logic [31:0] a,
                                input logic [31:0] d, input int ack_delay,
                                input logic [31:0] rdata);
    int n;
    cuOP = op; addr = a; storeData = d; start = 1'b1;
    #1;
    check_output("stall_start", 32'(stall), 32'd1);
    check_output("busreq_start", 32'(busReq), 32'd0);
    step();
    start = 1'b0; cuOP = 6'd0; addr = $urandom(); storeData = $urandom();
    #1;
    if (op_misaligned(op, a)) begin
      check_output("misalign_pulse", 32'(misalign), 32'd1);
      check_output("misalign_noreq", 32'(busReq), 32'd0);
      check_output("misalign_stall", 32'(stall), 32'd0);
      check_output("misalign_timeout", 32'(timeoutErr), 32'd0);
      step();
      check_output("misalign_clear", 32'(misalign), 32'd0);
      check_output("misalign_idle_req", 32'(busReq), 32'd0);
      return;
    end
    check_output("req_wen", 32'(busWen), 32'(op_is_store(op)));
    check_output("req_ben", 32'(busBen), 32'(model_ben(op, a)));
    check_output("req_wdata", busWdata, model_wdata(op, d));
    check_output("req_stall", 32'(stall), 32'd1);
    n = 0;
    while (n < ack_delay && n < TIMEOUT) begin
      busRdata = $urandom();
      #1;
      check_output("req_busreq", 32'(busReq), 32'd1);
      check_output("req_addr", busAddr, a - (a % 4));
      check_output("req_nodone", 32'(done), 32'd0);
      step();
      n++;
    end
    if (ack_delay < TIMEOUT) begin
      busAck = 1'b1; busRdata = rdata;
      #1;
      check_output("ack_busreq", 32'(busReq), 32'd1);
      step();
      busAck = 1'b0; busRdata = $urandom();
      #1;
      if (!op_is_store(op)) model_memload = rdata >> (8 * (a % 4));
      check_output("done_pulse", 32'(done), 32'd1);
      check_output("done_busreq", 32'(busReq), 32'd0);
      check_output("done_stall", 32'(stall), 32'd0);
      check_output("done_memload", memload, model_memload);
      step();
      check_output("done_clear", 32'(done), 32'd0);
    end else begin
      check_output("timeout_pulse", 32'(timeoutErr), 32'd1);
      check_output("timeout_noreq", 32'(busReq), 32'd0);
      check_output("timeout_nodone", 32'(done), 32'd0);
      check_output("timeout_misalign", 32'(misalign), 32'd0);
      check_output("timeout_memload", memload, model_memload);
      step();
      check_output("timeout_clear", 32'(timeoutErr), 32'd0);
      check_output("timeout_idle", 32'(busReq), 32'd0);
    end
  endtask

  initial begin
    logic [5:0]  op;
    logic [31:0] a;
    int          r;
    int          dly;
    checks = 0; errors = 0; model_memload = 32'd0;
    nRst = 1'b0; start = 1'b0; cuOP = 6'd0; addr = 32'd0; storeData = 32'd0;
    busAck = 1'b0; busRdata = 32'd0;
    step();
    step();
    check_output("rst_busreq", 32'(busReq), 32'd0);
    check_output("rst_done", 32'(done), 32'd0);
    check_output("rst_stall", 32'(stall), 32'd0);
    check_output("rst_misalign", 32'(misalign), 32'd0);
    check_output("rst_timeout", 32'(timeoutErr), 32'd0);
    check_output("rst_memload", memload, 32'd0);
    check_output("rst_ben", 32'(busBen), 32'd0);
    check_output("rst_addr", busAddr, 32'd0);
    check_output("rst_wdata", busWdata, 32'd0);
    check_output("rst_wen", 32'(busWen), 32'd0);
    nRst = 1'b1;
    step();

    $display("[TB] SB with ack on first REQ cycle");
    apply_stimulus(6'd15, 32'h0000_1002, 32'h0000_00AB, 0, 32'h0);
    $display("[TB] LHU from upper half");
    apply_stimulus(6'd14, 32'h0000_2002, 32'h0, 2, 32'hBEEF_1234);
    $display("[TB] misaligned LW");
    apply_stimulus(6'd12, 32'h0000_3001, 32'h0, 0, 32'h0);
    $display("[TB] LW timeout");
    apply_stimulus(6'd12, 32'h0000_3000, 32'h0, TIMEOUT, 32'h0);
    $display("[TB] LB with ack in final allowed cycle");
    apply_stimulus(6'd10, 32'h0000_5003, 32'h0, TIMEOUT - 1, 32'hA1B2_C3D4);

    $display("[TB] reset during SW wait");
    cuOP = 6'd17; addr = 32'h0000_4000; storeData = 32'h1234_5678; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    check_output("rstmid_busreq_before", 32'(busReq), 32'd1);
    nRst = 1'b0;
    step();
    nRst = 1'b1;
    model_memload = 32'd0;
    #1;
    check_output("rstmid_busreq", 32'(busReq), 32'd0);
    check_output("rstmid_ben", 32'(busBen), 32'd0);
    check_output("rstmid_memload", memload, 32'd0);
    busAck = 1'b1;
    step();
    busAck = 1'b0;
    check_output("rstmid_nodone", 32'(done), 32'd0);
    step();
    check_output("rstmid_nodone2", 32'(done), 32'd0);
    check_output("rstmid_idle", 32'(busReq), 32'd0);

    $display("[TB] non-memory op ignored");
    cuOP = 6'd0; addr = 32'h0000_1000; start = 1'b1;
    #1;
    check_output("alu_stall", 32'(stall), 32'd0);
    step();
    check_output("alu_busreq", 32'(busReq), 32'd0);
    check_output("alu_stall_next", 32'(stall), 32'd0);
    check_output("alu_done", 32'(done), 32'd0);
    check_output("alu_misalign", 32'(misalign), 32'd0);
    start = 1'b0;
    step();

    $display("[TB] randomized transfers");
    for (int i = 0; i < 40; i++) begin
      op = 6'(10 + $urandom_range(0, 7));
      a = $urandom();
      if ($urandom_range(0, 2) != 0) a = a - (a % op_size(op));
      r = $urandom_range(0, 9);
      dly = (r < 7) ? r : ((r == 7) ? TIMEOUT - 1 : ((r == 8) ? TIMEOUT : 1));
      apply_stimulus(op, a, $urandom(), dly, $urandom());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
